// File: rtl/measure_gen_if.sv
// rtl/measure_gen_if.sv - XGMII transmit lane bundle for measure_gen
interface measure_gen_if;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;

    modport master (output xgmii_txd, output xgmii_txc);
    modport slave  (input  xgmii_txd, input  xgmii_txc);
endinterface

// File: rtl/measure_gen.sv
// rtl/measure_gen.sv - timestamped UDP/IPv4 test-frame generator on XGMII TX; MEASURE_GEN_FCS_EN adds CRC-32 FCS
module measure_gen #(
    parameter logic [31:0] Int_ipv4_addr = {8'd10, 8'd0, 8'd21, 8'd105},
    parameter logic [47:0] Int_mac_addr  = 48'h003776_000101,
    parameter logic [15:0] UDP_SPORT     = 16'd3422,
    parameter logic [15:0] UDP_DPORT     = 16'd3422,
    parameter logic [31:0] MAGIC_CODE    = 32'hCAFE_F00D
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [31:0]   global_counter,
    input  logic          tx_enable,
    input  logic [10:0]   tx_frame_len,
    input  logic [7:0]    tx_ifg_words,
    input  logic [31:0]   tx_burst,
    input  logic [47:0]   tx_dst_mac,
    input  logic [31:0]   tx_dst_ip,
    measure_gen_if.master xgmii,
    output logic [31:0]   tx_frames,
    output logic          tx_busy,
    output logic          tx_done
);
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;

    typedef enum logic [2:0] {IDLE, START, DATA, TERM, IFG} state_t;
    state_t state, state_next;

    logic [10:0] len_q;
    logic [7:0]  ifg_q;
    logic [47:0] dst_mac_q;
    logic [31:0] dst_ip_q;
    logic [31:0] ts_q;
    logic [15:0] ip_csum_q;
    logic [7:0]  cnt_q;
    logic [31:0] frames_q;
    logic        done_q;
    logic        en_d;
    logic        clr_pend;
    logic [31:0] fcs;

    logic [10:0]  len_clamp, len_next;
    logic         en_rise, clr_now, done_eff, burst_hit;
    logic [7:0]   last_word, ifg_last;
    logic [15:0]  ip_len, udp_len, ip_csum;
    logic [19:0]  csum_sum;
    logic [16:0]  csum_f1;
    logic [15:0]  csum_f2;
    logic [447:0] hdr_be;
    logic [63:0]  hdr_w [8];
    logic [63:0]  word_be, data_pl, data_word;
    logic [63:0]  txd;
    logic [7:0]   txc;

    always_comb begin
        len_clamp = (tx_frame_len < 11'd64)   ? 11'd64 :
                    (tx_frame_len > 11'd1518) ? 11'd1518 : tx_frame_len;
        len_next  = len_clamp & 11'h7F8;
    end

    assign en_rise   = tx_enable & ~en_d;
    // A rising edge seen mid-frame is deferred until the FSM is back in IDLE.
    assign clr_now   = (state == IDLE) && (en_rise || clr_pend);
    assign done_eff  = done_q & ~clr_now;
    assign burst_hit = (tx_burst != 32'd0) && (frames_q == tx_burst);
    assign last_word = len_q[10:3] - 8'd1;
    assign ifg_last  = (ifg_q == 8'd0) ? 8'd0 : ifg_q - 8'd1;
    assign ip_len    = {5'd0, len_q - 11'd18};
    assign udp_len   = {5'd0, len_q - 11'd38};

    always_comb begin
        csum_sum = {4'h0, 16'h4500} + {4'h0, ip_len} + {4'h0, frames_q[15:0]} +
                   {4'h0, 16'h4000} + {4'h0, 16'h4011} +
                   {4'h0, Int_ipv4_addr[31:16]} + {4'h0, Int_ipv4_addr[15:0]} +
                   {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
        csum_f1  = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
        csum_f2  = csum_f1[15:0] + {15'h0, csum_f1[16]};
        ip_csum  = ~csum_f2;
    end

    // Header bytes 0..55 in wire order, first byte in the MSBs.
    assign hdr_be = {dst_mac_q, Int_mac_addr, 16'h0800, 8'h45, 8'h00, ip_len,
                     frames_q[15:0], 16'h4000, 8'h40, 8'h11, ip_csum_q,
                     Int_ipv4_addr, dst_ip_q, UDP_SPORT, UDP_DPORT, udp_len,
                     16'h0000, MAGIC_CODE, ts_q, frames_q, 16'h0000};

    always_comb begin
        for (int i = 0; i < 7; i++) hdr_w[i] = hdr_be[447 - 64*i -: 64];
        hdr_w[7] = 64'h0;
        word_be  = (cnt_q < 8'd7) ? hdr_w[cnt_q[2:0]] : 64'h0;
        for (int k = 0; k < 8; k++) data_pl[8*k +: 8] = word_be[63 - 8*k -: 8];
        data_word = (cnt_q == last_word) ? {fcs, data_pl[31:0]} : data_pl;
    end

`ifdef MEASURE_GEN_FCS_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_word8(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = crc_byte(r, d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] crc_word4(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 4; k++) r = crc_byte(r, d[8*k +: 8]);
        return r;
    endfunction

    // The last word folds its four payload bytes in combinationally, so FCS needs no extra cycle.
    assign fcs = ~crc_word4(crc_q, data_pl[31:0]);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)          crc_q <= 32'hFFFFFFFF;
        else if (state == START) crc_q <= 32'hFFFFFFFF;
        else if (state == DATA)  crc_q <= crc_word8(crc_q, data_pl);
    end
`else
    assign fcs = 32'h0;
`endif

    always_comb begin
        state_next = state;
        txd        = IDLE_WORD;
        txc        = 8'hFF;
        case (state)
            IDLE:  if (tx_enable && !done_eff) state_next = START;
            START: begin
                txd        = START_WORD;
                txc        = 8'h01;
                state_next = DATA;
            end
            DATA: begin
                txd = data_word;
                txc = 8'h00;
                if (cnt_q == last_word) state_next = TERM;
            end
            TERM: begin
                txd        = TERM_WORD;
                state_next = IFG;
            end
            IFG: if (cnt_q == ifg_last) begin
                if (burst_hit)      state_next = IDLE;
                else if (tx_enable) state_next = START;
                else                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            len_q     <= 11'd64;
            ifg_q     <= 8'd0;
            dst_mac_q <= 48'h0;
            dst_ip_q  <= 32'h0;
            ts_q      <= 32'h0;
            ip_csum_q <= 16'h0;
            cnt_q     <= 8'd0;
            frames_q  <= 32'd0;
            done_q    <= 1'b0;
            en_d      <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            state <= state_next;
            en_d  <= tx_enable;
            if (state_next == START) begin
                len_q     <= len_next;
                ifg_q     <= tx_ifg_words;
                dst_mac_q <= tx_dst_mac;
                dst_ip_q  <= tx_dst_ip;
            end
            if (state == START) begin
                ts_q      <= global_counter;
                ip_csum_q <= ip_csum;
            end
            if ((state == DATA || state == IFG) && state_next == state) cnt_q <= cnt_q + 8'd1;
            else                                                        cnt_q <= 8'd0;
            if (clr_now)            frames_q <= 32'd0;
            else if (state == TERM) frames_q <= frames_q + 32'd1;
            if (clr_now || !tx_enable)                              done_q <= 1'b0;
            else if (state == IFG && state_next != IFG && burst_hit) done_q <= 1'b1;
            if (clr_now)                         clr_pend <= 1'b0;
            else if (en_rise && state != IDLE)   clr_pend <= 1'b1;
        end
    end

    assign xgmii.xgmii_txd = txd;
    assign xgmii.xgmii_txc = txc;
    assign tx_frames       = frames_q;
    assign tx_busy         = (state != IDLE);
    assign tx_done         = done_q;
endmodule

// File: tb/tb_measure_gen.sv
// tb/tb_measure_gen.sv - scoreboard bench for measure_gen; honours MEASURE_GEN_FCS_EN
module tb_measure_gen;
    localparam logic [31:0] MAGIC  = 32'hCAFE_F00D;
    localparam logic [31:0] SRC_IP = {8'd10, 8'd0, 8'd21, 8'd105};
    localparam logic [47:0] SRC_MAC = 48'h003776_000101;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] global_counter;
    logic        tx_enable;
    logic [10:0] tx_frame_len;
    logic [7:0]  tx_ifg_words;
    logic [31:0] tx_burst;
    logic [47:0] tx_dst_mac;
    logic [31:0] tx_dst_ip;
    logic [31:0] tx_frames;
    logic        tx_busy, tx_done;

    measure_gen_if xif();

    measure_gen dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .global_counter(global_counter),
        .tx_enable(tx_enable), .tx_frame_len(tx_frame_len), .tx_ifg_words(tx_ifg_words),
        .tx_burst(tx_burst), .tx_dst_mac(tx_dst_mac), .tx_dst_ip(tx_dst_ip),
        .xgmii(xif), .tx_frames(tx_frames), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    logic [7:0] cap[$];
    logic [7:0] last_frame[$];
    int         periods[$];
    int         cyc = 0, last_start = -1, starts = 0, fd_cnt = 0, aborted = 0;
    bit         in_frame = 0;

    task automatic push_frame(input int L, input logic [31:0] seq, input logic [31:0] ts);
        logic [7:0]  f [0:1511];
        logic [31:0] s, crc;
        for (int i = 0; i < 1512; i++) f[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            f[i]     = tx_dst_mac[47 - 8*i -: 8];
            f[6 + i] = SRC_MAC[47 - 8*i -: 8];
        end
        f[12] = 8'h08; f[14] = 8'h45;
        {f[16], f[17]} = 16'(L - 18);
        {f[18], f[19]} = seq[15:0];
        f[20] = 8'h40; f[22] = 8'h40; f[23] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            f[26 + i] = SRC_IP[31 - 8*i -: 8];
            f[30 + i] = tx_dst_ip[31 - 8*i -: 8];
            f[42 + i] = MAGIC[31 - 8*i -: 8];
            f[46 + i] = ts[31 - 8*i -: 8];
            f[50 + i] = seq[31 - 8*i -: 8];
        end
        {f[34], f[35]} = 16'd3422;
        {f[36], f[37]} = 16'd3422;
        {f[38], f[39]} = 16'(L - 38);
        s = 0;
        for (int i = 14; i < 34; i += 2) s += {16'h0, f[i], f[i + 1]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        {f[24], f[25]} = ~s[15:0];
`ifdef MEASURE_GEN_FCS_EN
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < L - 4; i++) begin
            crc ^= {24'h0, f[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) f[L - 4 + i] = crc[8*i +: 8];
`else
        crc = 32'h0;
`endif
        for (int i = 0; i < L; i++) exp_bytes.push_back(f[i]);
        exp_lens.push_back(L);
    endtask

    task automatic compare_frame();
        int L, nbad, first;
        logic [7:0] e;
        if (exp_lens.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            return;
        end
        L = exp_lens.pop_front();
        chk("frame_len", cap.size(), L);
        nbad = 0; first = -1;
        for (int i = 0; i < L; i++) begin
            e = exp_bytes.pop_front();
            if (i >= cap.size() || cap[i] !== e) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("frame_bytes(first_bad@%0d)", first), nbad, 0);
        last_frame = cap;
    endtask

    always @(negedge sys_clk) begin
        cyc++;
        if (xif.xgmii_txc[0] && xif.xgmii_txd[7:0] == 8'hFD) fd_cnt++;
        if (xif.xgmii_txc == 8'h01) begin
            chk("start_word", xif.xgmii_txd, PRE_W);
            if (last_start >= 0) periods.push_back(cyc - last_start);
            last_start = cyc;
            starts++;
            in_frame = 1;
            cap.delete();
        end else if (in_frame && xif.xgmii_txc == 8'h00) begin
            for (int k = 0; k < 8; k++) cap.push_back(xif.xgmii_txd[8*k +: 8]);
        end else if (in_frame) begin
            in_frame = 0;
            if (xif.xgmii_txc == 8'hFF && xif.xgmii_txd == TERM_W) compare_frame();
            else aborted++;
        end
    end

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!tx_done && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        chk("done_timeout", tx_done, 1);
    endtask

    function automatic logic [15:0] hdr_sum();
        logic [31:0] s = 0;
        for (int i = 14; i < 34; i += 2) s += {16'h0, last_frame[i], last_frame[i + 1]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic restart_prep();
        tx_enable = 1'b0;
        repeat (3) @(negedge sys_clk);
        periods.delete();
        last_start = -1;
    endtask

    int in_lens[3]  = '{1600, 20, 100};
    int exp_l[3]    = '{1512, 64, 96};
    int starts_t, fd_before, ab_before;

    initial begin
        sys_rst_n = 1'b0; tx_enable = 1'b0; tx_frame_len = 11'd64; tx_ifg_words = 8'd1;
        tx_burst = 32'd0; tx_dst_mac = 48'h001122334455; tx_dst_ip = {8'd10, 8'd0, 8'd21, 8'd1};
        global_counter = 32'h0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_txd", xif.xgmii_txd, IDLE_W);
        chk("rst_txc", xif.xgmii_txc, 8'hFF);
        chk("rst_frames", tx_frames, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // burst of three minimum frames
        global_counter = 32'h12345678; tx_burst = 32'd3;
        for (int s = 0; s < 3; s++) push_frame(64, s, 32'h12345678);
        starts_t = starts;
        tx_enable = 1'b1;
        wait_done(100);
        repeat (2) @(negedge sys_clk);
        chk("b3_frames", tx_frames, 3);
        chk("b3_done", tx_done, 1);
        chk("b3_busy", tx_busy, 0);
        chk("b3_idle_txd", xif.xgmii_txd, IDLE_W);
        chk("b3_idle_txc", xif.xgmii_txc, 8'hFF);
        chk("b3_starts", starts - starts_t, 3);
        chk("b3_periods", periods.size(), 2);
        foreach (periods[i]) chk("b3_period", periods[i], 11);
        chk("b3_pending", exp_lens.size(), 0);
        chk("b3_magic", {last_frame[42], last_frame[43], last_frame[44], last_frame[45]}, MAGIC);
        chk("b3_ts", {last_frame[46], last_frame[47], last_frame[48], last_frame[49]}, 32'h12345678);
        chk("b3_ipcsum_valid", hdr_sum(), 16'hFFFF);

        // length clamping and rounding
        for (int i = 0; i < 3; i++) begin
            restart_prep();
            tx_burst = 32'd1; tx_frame_len = 11'(in_lens[i]); tx_ifg_words = 8'd0;
            global_counter = 32'hA5A50000 + i;
            push_frame(exp_l[i], 0, global_counter);
            tx_enable = 1'b1;
            wait_done(300);
            repeat (2) @(negedge sys_clk);
            chk($sformatf("len%0d_frames", in_lens[i]), tx_frames, 1);
            chk($sformatf("len%0d_iplen", in_lens[i]), {last_frame[16], last_frame[17]}, 16'(exp_l[i] - 18));
            chk($sformatf("len%0d_pending", in_lens[i]), exp_lens.size(), 0);
        end

        // drop enable during DATA word 4 of a 128-byte frame
        restart_prep();
        tx_burst = 32'd0; tx_frame_len = 11'd128; tx_ifg_words = 8'd2; global_counter = 32'h0BADBEEF;
        push_frame(128, 0, global_counter);
        starts_t = starts;
        tx_enable = 1'b1;
        repeat (6) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("drop_busy_at_drop", tx_busy, 1);
        tx_enable = 1'b0;
        repeat (40) @(negedge sys_clk);
        chk("drop_starts", starts - starts_t, 1);
        chk("drop_frames", tx_frames, 1);
        chk("drop_busy", tx_busy, 0);
        chk("drop_done", tx_done, 0);
        chk("drop_pending", exp_lens.size(), 0);

        // reset during DATA word 2 of the third frame
        restart_prep();
        tx_burst = 32'd0; tx_frame_len = 11'd64; tx_ifg_words = 8'd1; global_counter = 32'h00C0FFEE;
        push_frame(64, 0, global_counter);
        push_frame(64, 1, global_counter);
        ab_before = aborted;
        tx_enable = 1'b1;
        repeat (26) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rstmid_frames_before", tx_frames, 2);
        fd_before = fd_cnt;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("rstmid_txd", xif.xgmii_txd, IDLE_W);
        chk("rstmid_txc", xif.xgmii_txc, 8'hFF);
        chk("rstmid_frames", tx_frames, 0);
        chk("rstmid_busy", tx_busy, 0);
        tx_enable = 1'b0;
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("rstmid_no_term", fd_cnt - fd_before, 0);
        chk("rstmid_aborted", aborted - ab_before, 1);
        chk("rstmid_pending", exp_lens.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
